// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and default sizes for the instruction/data memory arbiter.
// Latency: n/a, declarations only.
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MEM_LAT = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes plus single-port memory bus around the arbiter.
// Latency: n/a, wiring only.
// Backpressure: requesters hold req until gnt; the memory has fixed read latency and no stall.
import mem_arb_pkg::*;

interface mem_arbiter_if #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // requesters and memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between fetch and data requests (MEM_ARB_RR_EN = round-robin).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller only consumes the result while idle.
import mem_arb_pkg::*;

module mem_arb_pick (
  input  logic   i_req,
  input  logic   d_req,
`ifdef MEM_ARB_RR_EN
  input  owner_t last,
`endif
  output logic   any_req,
  output owner_t win
);

  // choose the owner of the next access
  always_comb begin
    any_req = i_req | d_req;
    win     = OWN_D;
`ifdef MEM_ARB_RR_EN
    // on a tie the side that was not granted last goes next
    if (i_req && d_req) begin
      win = (last == OWN_I) ? OWN_D : OWN_I;
    end else if (i_req) begin
      win = OWN_I;
    end
`else
    // data always beats fetch
    if (i_req && !d_req) begin
      win = OWN_I;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store, one access in flight (MEM_ARB_RR_EN = round-robin).
// Latency: gnt 1 cycle after req is seen in IDLE, done MEM_LAT+2 cycles after that edge.
// Backpressure: requests are ignored while busy; a requester holds req until it sees its gnt pulse.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  owner_t            owner_q;
  owner_t            win;
  logic              any_req;
  logic              we_q;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              mem_en;
  logic              mem_we;
  logic              i_gnt;
  logic              d_gnt;
  logic              i_done;
  logic              d_done;

`ifdef MEM_ARB_RR_EN
  owner_t            last_q;
`endif

  mem_arb_pick u_pick (
    .i_req   (bus.i_req),
    .d_req   (bus.d_req),
`ifdef MEM_ARB_RR_EN
    .last    (last_q),
`endif
    .any_req (any_req),
    .win     (win)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and the per-state strobes
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        i_gnt     = (owner_q == OWN_I);
        d_gnt     = (owner_q == OWN_D);
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        i_done    = (owner_q == OWN_I);
        d_done    = (owner_q == OWN_D);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // latch the winner's request, count the wait, capture read data on the last wait edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q   <= OWN_D;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_q <= win;
            if (win == OWN_D) begin
              we_q    <= bus.d_we;
              addr_q  <= bus.d_addr;
              wdata_q <= bus.d_wdata;
            end else begin
              // fetches are read-only
              we_q    <= 1'b0;
              addr_q  <= bus.i_addr;
              wdata_q <= '0;
            end
          end
        end
        ACCESS: cnt_q <= 3'(MEM_LAT);
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1 && !we_q) begin
            if (owner_q == OWN_I) begin
              i_rdata_q <= bus.mem_rdata;
            end else begin
              d_rdata_q <= bus.mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  // remember who was granted so a tie goes to the other side next time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWN_D;
    end else if (state == ACCESS) begin
      last_q <= owner_q;
    end
  end
`endif

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.i_done    = i_done;
  assign bus.d_done    = d_done;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter at MEM_LAT=1 and MEM_LAT=3 against a latency-accurate memory model.
// Latency: n/a.
// Backpressure: requesters drop req on their gnt unless a test holds them high.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) b1 ();
  mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) b3 ();

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  // memory models: read data is valid only exactly MEM_LAT edges after the enable edge
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [7:0]  v1, v3;
  logic [31:0] p1 [8];
  logic [31:0] p3 [8];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= '0;
      mem1[8'h10] <= 32'hDEADBEEF;
    end else begin
      v1    <= {v1[6:0], b1.mem_en & ~b1.mem_we};
      p1[0] <= mem1[b1.mem_addr];
      for (int k = 1; k < 8; k++) p1[k] <= p1[k-1];
      if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
    end
  end
  assign b1.mem_rdata = v1[0] ? p1[0] : 32'hA5A5A5A5;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      v3 <= '0;
      mem3[8'h10] <= 32'h0BADF00D;
      mem3[8'h30] <= 32'h600DCAFE;
    end else begin
      v3    <= {v3[6:0], b3.mem_en & ~b3.mem_we};
      p3[0] <= mem3[b3.mem_addr];
      for (int k = 1; k < 8; k++) p3[k] <= p3[k-1];
      if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
    end
  end
  assign b3.mem_rdata = v3[2] ? p3[2] : 32'hA5A5A5A5;

  // observations collected by run1 on the MEM_LAT=1 instance
  int          ig_c[$], dg_c[$], id_c[$], dd_c[$];
  byte         order[$];
  int          en_n, we_n;
  logic [7:0]  last_addr;
  logic [31:0] last_wdata;
  logic [31:0] i_rd_done, d_rd_done;

  task automatic run1(input int n, input bit hold);
    ig_c.delete(); dg_c.delete(); id_c.delete(); dd_c.delete(); order.delete();
    en_n = 0; we_n = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (b1.i_gnt) begin ig_c.push_back(c); order.push_back("I"); if (!hold) b1.i_req = 1'b0; end
      if (b1.d_gnt) begin dg_c.push_back(c); order.push_back("D"); if (!hold) b1.d_req = 1'b0; end
      if (b1.i_done) begin id_c.push_back(c); i_rd_done = b1.i_rdata; end
      if (b1.d_done) begin dd_c.push_back(c); d_rd_done = b1.d_rdata; end
      if (b1.mem_en) begin en_n++; last_addr = b1.mem_addr; last_wdata = b1.mem_wdata; end
      if (b1.mem_we) we_n++;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (b1.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", b1.busy); end
    total++;
    if ({b1.i_gnt, b1.d_gnt, b1.i_done, b1.d_done, b1.mem_en, b1.mem_we} !== 6'b0) begin
      bad++; $display("FAIL rst_strobes: got %b want 000000",
                      {b1.i_gnt, b1.d_gnt, b1.i_done, b1.d_done, b1.mem_en, b1.mem_we});
    end
    total++;
    if ({b1.mem_addr, b1.mem_wdata} !== 40'h0) begin
      bad++; $display("FAIL rst_mem_bus: got %h/%h want 0/0", b1.mem_addr, b1.mem_wdata);
    end
    total++;
    if ({b1.i_rdata, b1.d_rdata} !== 64'h0) begin
      bad++; $display("FAIL rst_rdata: got %h/%h want 0/0", b1.i_rdata, b1.d_rdata);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_fetch();
    b1.i_req = 1'b1; b1.i_addr = 8'h10;
    run1(5, 1'b0);
    total++; if (ig_c.size() !== 1 || ig_c[0] !== 1) begin bad++; $display("FAIL fetch_gnt: got n=%0d c=%0d want n=1 c=1", ig_c.size(), ig_c[0]); end
    total++; if (id_c.size() !== 1 || id_c[0] !== 3) begin bad++; $display("FAIL fetch_done: got n=%0d c=%0d want n=1 c=3", id_c.size(), id_c[0]); end
    total++; if (dg_c.size() + dd_c.size() !== 0) begin bad++; $display("FAIL fetch_no_data: got %0d data pulses want 0", dg_c.size() + dd_c.size()); end
    total++; if (en_n !== 1 || we_n !== 0 || last_addr !== 8'h10) begin bad++; $display("FAIL fetch_mem: got en=%0d we=%0d addr=%h want 1 0 10", en_n, we_n, last_addr); end
    total++; if (i_rd_done !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_rdata_done: got %h want deadbeef", i_rd_done); end
    total++; if (b1.i_rdata !== 32'hDEADBEEF || b1.busy !== 1'b0) begin bad++; $display("FAIL fetch_hold: got %h busy=%b want deadbeef busy=0", b1.i_rdata, b1.busy); end
  endtask

  task automatic test_store(input logic [7:0] a, input logic [31:0] wd, input logic [31:0] exp_d);
    b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = a; b1.d_wdata = wd;
    run1(5, 1'b0);
    b1.d_we = 1'b0;
    total++; if (dg_c.size() !== 1 || dg_c[0] !== 1) begin bad++; $display("FAIL store_gnt: got n=%0d c=%0d want n=1 c=1", dg_c.size(), dg_c[0]); end
    total++; if (dd_c.size() !== 1 || dd_c[0] !== 3) begin bad++; $display("FAIL store_done: got n=%0d c=%0d want n=1 c=3", dd_c.size(), dd_c[0]); end
    total++; if (en_n !== 1 || we_n !== 1) begin bad++; $display("FAIL store_strobes: got en=%0d we=%0d want 1 1", en_n, we_n); end
    total++; if (last_addr !== a || last_wdata !== wd) begin bad++; $display("FAIL store_bus: got %h/%h want %h/%h", last_addr, last_wdata, a, wd); end
    total++; if (b1.d_rdata !== exp_d) begin bad++; $display("FAIL store_rdata_kept: got %h want %h", b1.d_rdata, exp_d); end
    total++; if (mem1[a] !== wd) begin bad++; $display("FAIL store_mem: got %h want %h", mem1[a], wd); end
  endtask

  task automatic test_load(input logic [7:0] a, input logic [31:0] exp_d);
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = a; b1.d_wdata = 32'hFFFFFFFF;
    run1(5, 1'b0);
    total++; if (dd_c.size() !== 1 || dd_c[0] !== 3) begin bad++; $display("FAIL load_done: got n=%0d c=%0d want n=1 c=3", dd_c.size(), dd_c[0]); end
    total++; if (we_n !== 0 || last_addr !== a) begin bad++; $display("FAIL load_bus: got we=%0d addr=%h want 0 %h", we_n, last_addr, a); end
    total++; if (d_rd_done !== exp_d) begin bad++; $display("FAIL load_rdata: got %h want %h", d_rd_done, exp_d); end
    total++; if (b1.i_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL load_irdata_kept: got %h want deadbeef", b1.i_rdata); end
  endtask

  task automatic test_priority();
    int fi, fd;
    pulse_reset();
    b1.i_req = 1'b1; b1.i_addr = 8'h10;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 8'h20;
    run1(10, 1'b0);
`ifdef MEM_ARB_RR_EN
    fi = 1; fd = 5;
`else
    fi = 5; fd = 1;
`endif
    total++; if (dg_c.size() !== 1 || dg_c[0] !== fd) begin bad++; $display("FAIL prio_dgnt: got n=%0d c=%0d want n=1 c=%0d", dg_c.size(), dg_c[0], fd); end
    total++; if (ig_c.size() !== 1 || ig_c[0] !== fi) begin bad++; $display("FAIL prio_ignt: got n=%0d c=%0d want n=1 c=%0d", ig_c.size(), ig_c[0], fi); end
    total++; if (dd_c.size() !== 1 || id_c.size() !== 1 || id_c[0] - dd_c[0] !== (fi - fd)) begin
      bad++; $display("FAIL prio_done_gap: got i_done=%0d d_done=%0d want gap %0d", id_c[0], dd_c[0], fi - fd);
    end
    total++; if (i_rd_done !== 32'hDEADBEEF || d_rd_done !== 32'hCAFEF00D) begin
      bad++; $display("FAIL prio_rdata: got %h/%h want deadbeef/cafef00d", i_rd_done, d_rd_done);
    end
  endtask

  task automatic test_rr();
    byte exp_o [4];
`ifdef MEM_ARB_RR_EN
    exp_o = '{"I", "D", "I", "D"};
`else
    exp_o = '{"D", "D", "D", "D"};
`endif
    pulse_reset();
    b1.i_req = 1'b1; b1.i_addr = 8'h10;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 8'h20;
    run1(15, 1'b1);
    b1.i_req = 1'b0; b1.d_req = 1'b0;
    total++; if (order.size() !== 4) begin bad++; $display("FAIL rr_count: got %0d grants want 4", order.size()); end
    for (int k = 0; k < 4; k++) begin
      total++; if (order[k] !== exp_o[k]) begin bad++; $display("FAIL rr_order%0d: got %c want %c", k, order[k], exp_o[k]); end
    end
    @(negedge clk);
    total++; if (b1.busy !== 1'b0) begin bad++; $display("FAIL rr_idle: got busy=%b want 0", b1.busy); end
  endtask

  task automatic test_reset_wait();
    int gc, dc, dn;
    logic [31:0] rd;
    b3.i_req = 1'b1; b3.i_addr = 8'h30;
    @(negedge clk);
    total++; if (b3.i_gnt !== 1'b1) begin bad++; $display("FAIL rw_gnt: got %b want 1", b3.i_gnt); end
    b3.i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (b3.busy !== 1'b0) begin bad++; $display("FAIL rw_busy: got %b want 0", b3.busy); end
    total++;
    if ({b3.i_gnt, b3.d_gnt, b3.i_done, b3.d_done, b3.mem_en, b3.mem_we, b3.mem_addr, b3.i_rdata} !== '0) begin
      bad++; $display("FAIL rw_outputs: got gnt/done/en/we=%b addr=%h rdata=%h want all 0",
                      {b3.i_gnt, b3.d_gnt, b3.i_done, b3.d_done, b3.mem_en, b3.mem_we}, b3.mem_addr, b3.i_rdata);
    end
    @(negedge clk); rst = 1'b1;
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (b3.i_done || b3.d_done) dn++;
    end
    total++; if (dn !== 0) begin bad++; $display("FAIL rw_no_done: got %0d done pulses want 0", dn); end
    b3.i_req = 1'b1; b3.i_addr = 8'h10;
    gc = 0; dc = 0; rd = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (b3.i_gnt) begin gc = c; b3.i_req = 1'b0; end
      if (b3.i_done) begin dc = c; rd = b3.i_rdata; end
    end
    total++; if (gc !== 1 || dc !== 5) begin bad++; $display("FAIL rw_after_timing: got gnt=%0d done=%0d want 1 5", gc, dc); end
    total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL rw_after_rdata: got %h want 0badf00d", rd); end
  endtask

  initial begin
    rst = 1'b0;
    b1.i_req = 1'b0; b1.i_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
    b3.i_req = 1'b0; b3.i_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0; b3.d_addr = '0; b3.d_wdata = '0;
    i_rd_done = '0; d_rd_done = '0; last_addr = '0; last_wdata = '0;
    test_reset();
    test_fetch();
    test_store(8'h20, 32'h12345678, 32'h00000000);
    test_load(8'h20, 32'h12345678);
    test_store(8'h20, 32'hCAFEF00D, 32'h12345678);
    test_priority();
    test_rr();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
